// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage sitting directly in front of the instruction decoder. It owns
//   the program counter and runs a req/ack handshake to instruction memory.
//   The fetched word is presented to the decoder as I. When the decoder
//   raises IF_NEXT_PC, the next PC is chosen from the decoder's branch
//   controls, evaluated against the PSTATE flags.
//
//   Sequence per instruction: REQ -> WAIT (until ack) -> HOLD (until the
//   decoder is done) -> REQ. Every instruction takes at least 3 cycles.
//
// Parameters
//   PC_W        PC / IMEM address width in bits (>= 28)
//   RESET_PC    PC value loaded on reset
//   TIMEOUT_CYC maximum number of IMEM wait cycles before a fetch fault.
//               Used only when IF_TIMEOUT_EN is defined.
//
// Configuration macro
//   IF_TIMEOUT_EN  When defined, a WAIT that sees no ack for TIMEOUT_CYC
//                  cycles ends in a fault. I is set to 0, I_VALID to 1, and
//                  the sticky FETCH_ERR flag is set.
//                  When undefined, WAIT waits indefinitely and FETCH_ERR is
//                  constant 0.
//
// Ports
//   CLK          in   1     clock, rising edge
//   RESET        in   1     asynchronous, active-high reset
//   BR_PC        in   1     unconditional branch (from decoder)
//   BR_PC_COND   in   1     conditional branch (from decoder)
//   IF_NEXT_PC   in   1     decoder is done with I; advance the PC
//   PSTATE_COND  in   4     branch condition code
//   PSTATE       in   4     flags {N,Z,C,V}
//   BR_OFFSET    in   26    signed branch offset, in words
//   IMEM_ADDR    out  PC_W  fetch address (equals PC)
//   IMEM_REQ     out  1     fetch request
//   IMEM_ACK     in   1     IMEM_RDATA is valid this cycle
//   IMEM_RDATA   in   32    instruction word from memory
//   I            out  32    registered instruction to the decoder
//   I_VALID      out  1     I holds a fetched instruction
//   PC           out  PC_W  address of the instruction in I
//   FETCH_ERR    out  1     sticky fetch timeout fault
// ---------------------------------------------------------------------------
module instruction_fetch #(
   parameter int unsigned     PC_W        = 32,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter int unsigned     TIMEOUT_CYC = 15
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            BR_PC,
   input  logic            BR_PC_COND,
   input  logic            IF_NEXT_PC,
   input  logic [3:0]      PSTATE_COND,
   input  logic [3:0]      PSTATE,
   input  logic [25:0]     BR_OFFSET,
   output logic [PC_W-1:0] IMEM_ADDR,
   output logic            IMEM_REQ,
   input  logic            IMEM_ACK,
   input  logic [31:0]     IMEM_RDATA,
   output logic [31:0]     I,
   output logic            I_VALID,
   output logic [PC_W-1:0] PC,
   output logic            FETCH_ERR
);

   // Elaboration-time parameter sanity checks.
   if (PC_W < 28) begin : g_bad_pc_w
      $error("instruction_fetch: PC_W must be >= 28 to hold a 26-bit word offset");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cyc
      $error("instruction_fetch: TIMEOUT_CYC must be >= 1");
   end

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [31:0]     i_q, i_d;
   logic            i_valid_q, i_valid_d;
   logic            req_q, req_d;

`ifdef IF_TIMEOUT_EN
   localparam int unsigned TMR_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   logic [TMR_W-1:0] timer_q, timer_d;
   logic             err_q, err_d;
`endif

   // ------------------------------------------------------------------
   // Branch condition evaluation
   // ------------------------------------------------------------------
   logic flag_n, flag_z, flag_c, flag_v;
   logic cond_true;

   assign {flag_n, flag_z, flag_c, flag_v} = PSTATE;

   always_comb begin
      cond_true = 1'b0;
      case (PSTATE_COND)
         4'h0:    cond_true = flag_z;                           // EQ
         4'h1:    cond_true = !flag_z;                          // NE
         4'h2:    cond_true = flag_c;                           // CS
         4'h3:    cond_true = !flag_c;                          // CC
         4'h4:    cond_true = flag_n;                           // MI
         4'h5:    cond_true = !flag_n;                          // PL
         4'h6:    cond_true = flag_v;                           // VS
         4'h7:    cond_true = !flag_v;                          // VC
         4'h8:    cond_true = flag_c && !flag_z;                // HI
         4'h9:    cond_true = !flag_c || flag_z;                // LS
         4'hA:    cond_true = (flag_n == flag_v);               // GE
         4'hB:    cond_true = (flag_n != flag_v);               // LT
         4'hC:    cond_true = !flag_z && (flag_n == flag_v);    // GT
         4'hD:    cond_true = flag_z || (flag_n != flag_v);     // LE
         4'hE:    cond_true = 1'b1;                             // AL
         default: cond_true = 1'b0;                             // NV
      endcase
   end

   // ------------------------------------------------------------------
   // Next-PC selection. Both adders wrap modulo 2^PC_W by construction.
   // ------------------------------------------------------------------
   logic [PC_W-1:0] off_bytes;
   logic [PC_W-1:0] target_pc;
   logic [PC_W-1:0] seq_pc;
   logic [PC_W-1:0] next_pc;

   // Sign-extend the word offset and scale it to bytes (<< 2).
   assign off_bytes = PC_W'({{PC_W{BR_OFFSET[25]}}, BR_OFFSET, 2'b00});
   assign target_pc = pc_q + off_bytes;
   assign seq_pc    = pc_q + PC_W'(4);

   // An unconditional branch wins even when BR_PC_COND is also set.
   assign next_pc   = (BR_PC || (BR_PC_COND && cond_true)) ? target_pc : seq_pc;

   // ------------------------------------------------------------------
   // Fetch FSM: next-state and datapath updates
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path through the case can infer a latch.
      state_d   = state_q;
      pc_d      = pc_q;
      i_d       = i_q;
      i_valid_d = i_valid_q;
      req_d     = req_q;
`ifdef IF_TIMEOUT_EN
      // The timer counts only while WAIT persists; any other path clears it.
      timer_d   = '0;
      err_d     = err_q;
`endif

      case (state_q)
         S_REQ: begin
            // IMEM_REQ is registered, so it becomes visible in the first WAIT cycle.
            req_d   = 1'b1;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (IMEM_ACK) begin
               // An ack wins over a timeout that expires in the same cycle.
               i_d       = IMEM_RDATA;
               i_valid_d = 1'b1;
               req_d     = 1'b0;
               state_d   = S_HOLD;
            end
`ifdef IF_TIMEOUT_EN
            else if (timer_q == TMR_LAST) begin
               // TIMEOUT_CYC cycles have passed with no ack: present a
               // zero word and set the sticky fault flag.
               i_d       = '0;
               i_valid_d = 1'b1;
               req_d     = 1'b0;
               err_d     = 1'b1;
               state_d   = S_HOLD;
            end else begin
               timer_d   = timer_q + TMR_W'(1);
            end
`endif
         end

         S_HOLD: begin
            // Branch controls are looked at only here, on the advance cycle.
            if (IF_NEXT_PC) begin
               pc_d      = next_pc;
               i_valid_d = 1'b0;
               state_d   = S_REQ;
            end
         end

         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_REQ;
         pc_q      <= RESET_PC;
         i_q       <= '0;
         i_valid_q <= 1'b0;
         req_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register here take its value from the same pre-edge state.
         state_q   <= state_d;
         pc_q      <= pc_d;
         i_q       <= i_d;
         i_valid_q <= i_valid_d;
         req_q     <= req_d;
      end
   end

`ifdef IF_TIMEOUT_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         timer_q <= '0;
         err_q   <= 1'b0;
      end else begin
         timer_q <= timer_d;
         err_q   <= err_d;
      end
   end

   assign FETCH_ERR = err_q;
`else
   assign FETCH_ERR = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign IMEM_ADDR = pc_q;
   assign IMEM_REQ  = req_q;
   assign I         = i_q;
   assign I_VALID   = i_valid_q;
   assign PC        = pc_q;

endmodule
